// File: rtl/tpu_sa_core.sv
// rtl/tpu_sa_core.sv - output-stationary PxP systolic matmul engine; TPU_SIGNED_EN selects signed operands
module tpu_sa_core #(
    parameter int P      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int DIM_W  = 8,
    parameter int IDX_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DIM_W-1:0]      K,
    input  logic [DIM_W-1:0]      M,
    input  logic [DIM_W-1:0]      N,
    output logic                  busy,
    output logic                  A_wr_en,
    output logic                  B_wr_en,
    output logic [IDX_W-1:0]      A_index,
    output logic [IDX_W-1:0]      B_index,
    output logic [P*DATA_W-1:0]   A_data_in,
    output logic [P*DATA_W-1:0]   B_data_in,
    input  logic [P*DATA_W-1:0]   A_data_out,
    input  logic [P*DATA_W-1:0]   B_data_out,
    output logic                  C_wr_en,
    output logic [IDX_W-1:0]      C_index,
    output logic [P*ACC_W-1:0]    C_data_in,
    input  logic [P*ACC_W-1:0]    C_data_out
);
    localparam int CW = DIM_W + 6;
    localparam int RW = $clog2(P);

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t            state;
    logic [DIM_W-1:0]  k_r, m_r, n_r;
    logic [CW-1:0]     cnt, row_base, col_base;
    logic [IDX_W-1:0]  a_base, b_base, cm_base;
    logic              rd_valid;

    logic [DATA_W-1:0]   a_sh [P][2*P-1];
    logic [DATA_W-1:0]   b_sh [P][2*P-1];
    logic [2*DATA_W-1:0] raw  [P][P];
    logic [ACC_W-1:0]    prod [P][P];
    logic [ACC_W-1:0]    acc  [P][P];

    logic [CW-1:0]     m_ext, n_ext, row_next, rem, rv_last;
    logic              last_row, last_col, clr;
    logic [IDX_W-1:0]  n_a_base, n_b_base, n_cm_base, c_idx_next;
    logic [RW-1:0]     ld_row;
    logic [P*ACC_W-1:0] wr_word;
    logic              unused_c;

    assign A_wr_en   = 1'b0;
    assign B_wr_en   = 1'b0;
    assign A_data_in = '0;
    assign B_data_in = '0;
    assign unused_c  = ^C_data_out;

    assign m_ext     = CW'(m_r);
    assign n_ext     = CW'(n_r);
    assign row_next  = row_base + CW'(P);
    assign last_row  = row_next >= m_ext;
    assign last_col  = (col_base + CW'(P)) >= n_ext;
    assign rem       = m_ext - row_base;
    assign rv_last   = (rem >= CW'(P)) ? CW'(P - 1) : rem - CW'(1);
    assign n_a_base  = last_row ? '0 : a_base + IDX_W'(k_r);
    assign n_b_base  = last_row ? b_base + IDX_W'(k_r) : b_base;
    assign n_cm_base = last_row ? cm_base + IDX_W'(m_r) : cm_base;
    assign clr       = (state == S_FEED) && (cnt == '0);

    // Output registers load one row ahead: row 0 in the last DRAIN cycle, row r+1 during write r
    assign ld_row     = (state == S_WRITE) ? RW'(cnt + CW'(1)) : '0;
    assign c_idx_next = cm_base + IDX_W'(row_base) + IDX_W'(ld_row);

    always_comb begin
        wr_word = '0;
        for (int j = 0; j < P; j++) begin
            if ((col_base + CW'(j)) < n_ext)
                wr_word[(P-1-j)*ACC_W +: ACC_W] = acc[ld_row][j];
        end
    end

    always_comb begin
        for (int i = 0; i < P; i++) begin
            for (int j = 0; j < P; j++) begin
`ifdef TPU_SIGNED_EN
                raw[i][j]  = {{DATA_W{a_sh[i][i+j][DATA_W-1]}}, a_sh[i][i+j]}
                           * {{DATA_W{b_sh[j][i+j][DATA_W-1]}}, b_sh[j][i+j]};
                prod[i][j] = ACC_W'($signed(raw[i][j]));
`else
                raw[i][j]  = {{DATA_W{1'b0}}, a_sh[i][i+j]} * {{DATA_W{1'b0}}, b_sh[j][i+j]};
                prod[i][j] = ACC_W'(raw[i][j]);
`endif
            end
        end
    end

    // Skew and systolic shift share one chain per lane: PE(i,j) taps stage i+j
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            for (int i = 0; i < P; i++) begin
                for (int s = 0; s < 2*P-1; s++) begin
                    a_sh[i][s] <= '0;
                    b_sh[i][s] <= '0;
                end
                for (int j = 0; j < P; j++)
                    acc[i][j] <= '0;
            end
        end else begin
            rd_valid <= (state == S_FEED);
            for (int i = 0; i < P; i++) begin
                a_sh[i][0] <= rd_valid ? A_data_out[(P-1-i)*DATA_W +: DATA_W] : '0;
                b_sh[i][0] <= rd_valid ? B_data_out[(P-1-i)*DATA_W +: DATA_W] : '0;
                for (int s = 1; s < 2*P-1; s++) begin
                    a_sh[i][s] <= a_sh[i][s-1];
                    b_sh[i][s] <= b_sh[i][s-1];
                end
                for (int j = 0; j < P; j++)
                    acc[i][j] <= clr ? '0 : acc[i][j] + prod[i][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            k_r       <= '0;
            m_r       <= '0;
            n_r       <= '0;
            cnt       <= '0;
            row_base  <= '0;
            col_base  <= '0;
            a_base    <= '0;
            b_base    <= '0;
            cm_base   <= '0;
            A_index   <= '0;
            B_index   <= '0;
            C_wr_en   <= 1'b0;
            C_index   <= '0;
            C_data_in <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        k_r      <= K;
                        m_r      <= M;
                        n_r      <= N;
                        cnt      <= '0;
                        row_base <= '0;
                        col_base <= '0;
                        a_base   <= '0;
                        b_base   <= '0;
                        cm_base  <= '0;
                        busy     <= 1'b1;
                        if (K == '0 || M == '0 || N == '0) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_FEED;
                            A_index <= '0;
                            B_index <= '0;
                        end
                    end
                end
                S_FEED: begin
                    if (cnt == CW'(k_r) - CW'(1)) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        A_index <= a_base + IDX_W'(cnt + CW'(1));
                        B_index <= b_base + IDX_W'(cnt + CW'(1));
                    end
                end
                S_DRAIN: begin
                    if (cnt == CW'(2*P - 1)) begin
                        state     <= S_WRITE;
                        cnt       <= '0;
                        C_wr_en   <= 1'b1;
                        C_index   <= c_idx_next;
                        C_data_in <= wr_word;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WRITE: begin
                    if (cnt == rv_last) begin
                        C_wr_en <= 1'b0;
                        cnt     <= '0;
                        if (last_row && last_col) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_FEED;
                            row_base <= last_row ? '0 : row_next;
                            col_base <= last_row ? col_base + CW'(P) : col_base;
                            a_base   <= n_a_base;
                            b_base   <= n_b_base;
                            cm_base  <= n_cm_base;
                            A_index  <= n_a_base;
                            B_index  <= n_b_base;
                        end
                    end else begin
                        cnt       <= cnt + CW'(1);
                        C_index   <= c_idx_next;
                        C_data_in <= wr_word;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_sa_core.sv
// tb/tb_tpu_sa_core.sv - scoreboard bench for tpu_sa_core
module tb_tpu_sa_core;
    localparam int P = 4, DW = 8, AW = 16, DIMW = 8, IW = 16;
    localparam int LIM = 4000;

    logic                clk = 1'b0;
    logic                rst_n, in_valid;
    logic [DIMW-1:0]     k_dim, m_dim, n_dim;
    logic                busy, a_wr_en, b_wr_en, c_wr_en;
    logic [IW-1:0]       a_index, b_index, c_index;
    logic [P*DW-1:0]     a_wdata, b_wdata, a_rdata, b_rdata;
    logic [P*AW-1:0]     c_wdata, c_rdata;

    logic [P*DW-1:0]     a_mem [0:65535];
    logic [P*DW-1:0]     b_mem [0:65535];
    logic [DW-1:0]       a_mat [0:7][0:255];
    logic [DW-1:0]       b_mat [0:255][0:7];

    logic [IW-1:0]       q_idx [$];
    logic [P*AW-1:0]     q_dat [$];

    int checks = 0, failures = 0, busy_cnt = 0, wr_cnt = 0;
    int eb, ew, t;
    logic [IW-1:0] a0;

    tpu_sa_core #(.P(P), .DATA_W(DW), .ACC_W(AW), .DIM_W(DIMW), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .K(k_dim), .M(m_dim), .N(n_dim), .busy(busy),
        .A_wr_en(a_wr_en), .B_wr_en(b_wr_en),
        .A_index(a_index), .B_index(b_index),
        .A_data_in(a_wdata), .B_data_in(b_wdata),
        .A_data_out(a_rdata), .B_data_out(b_rdata),
        .C_wr_en(c_wr_en), .C_index(c_index),
        .C_data_in(c_wdata), .C_data_out(c_rdata)
    );

    always #5 clk = ~clk;
    assign c_rdata = '0;

    always @(posedge clk) begin
        a_rdata <= a_mem[a_index];
        b_rdata <= b_mem[b_index];
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
`ifdef TPU_SIGNED_EN
        return $signed(v);
`else
        return int'(v);
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt = busy_cnt + 1;
            if (c_wr_en) begin
                wr_cnt = wr_cnt + 1;
                check_eq("c_write_queued", q_idx.size() != 0, 1);
                if (q_idx.size() != 0) begin
                    check_eq("c_index", c_index, q_idx.pop_front());
                    check_eq("c_data", c_wdata, q_dat.pop_front());
                end
            end
        end
    end

    // mode 0 identity, 1 constant v, 2 random
    task automatic fill(input int mode, input logic [DW-1:0] v);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 256; c++) begin
                case (mode)
                    0: begin a_mat[r][c] = DW'(r == c); b_mat[c][r] = DW'(r == c); end
                    1: begin a_mat[r][c] = v; b_mat[c][r] = v; end
                    default: begin a_mat[r][c] = DW'($urandom); b_mat[c][r] = DW'($urandom); end
                endcase
            end
        end
    endtask

    task automatic load_job(input int k, input int m, input int n, output int exp_busy, output int exp_wr);
        int rbn, cbn, rv, s;
        logic [P*DW-1:0] w;
        logic [P*AW-1:0] d;
        exp_busy = 1;
        exp_wr = 0;
        if (k == 0 || m == 0 || n == 0) return;
        rbn = (m + P - 1) / P;
        cbn = (n + P - 1) / P;
        for (int rb = 0; rb < rbn; rb++)
            for (int kk = 0; kk < k; kk++) begin
                for (int i = 0; i < P; i++)
                    w[(P-1-i)*DW +: DW] = (rb*P+i < m) ? a_mat[rb*P+i][kk] : 8'h33;
                a_mem[rb*k+kk] = w;
            end
        for (int cb = 0; cb < cbn; cb++)
            for (int kk = 0; kk < k; kk++) begin
                for (int j = 0; j < P; j++)
                    w[(P-1-j)*DW +: DW] = (cb*P+j < n) ? b_mat[kk][cb*P+j] : 8'h5A;
                b_mem[cb*k+kk] = w;
            end
        for (int cb = 0; cb < cbn; cb++)
            for (int rb = 0; rb < rbn; rb++) begin
                rv = (m - rb*P < P) ? m - rb*P : P;
                exp_busy = exp_busy + k + 2*P + rv;
                for (int r = 0; r < rv; r++) begin
                    d = '0;
                    for (int j = 0; j < P; j++) begin
                        if (cb*P+j < n) begin
                            s = 0;
                            for (int kk = 0; kk < k; kk++)
                                s = s + sx(a_mat[rb*P+r][kk]) * sx(b_mat[kk][cb*P+j]);
                            d[(P-1-j)*AW +: AW] = s[AW-1:0];
                        end
                    end
                    q_idx.push_back(IW'(cb*m + rb*P + r));
                    q_dat.push_back(d);
                    exp_wr = exp_wr + 1;
                end
            end
    endtask

    task automatic start_cmd(input int k, input int m, input int n);
        @(negedge clk);
        busy_cnt = 0;
        wr_cnt = 0;
        k_dim = DIMW'(k);
        m_dim = DIMW'(m);
        n_dim = DIMW'(n);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_job(input string tag, input int k, input int m, input int n, input bit pulse);
        int xb, xw, tt;
        load_job(k, m, n, xb, xw);
        start_cmd(k, m, n);
        if (pulse) begin
            repeat (4) @(negedge clk);
            k_dim = 8'd7; m_dim = 8'd2; n_dim = 8'd2;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
        tt = 0;
        while (busy && tt < LIM) begin
            @(negedge clk);
            tt = tt + 1;
        end
        check_eq({tag, "_done_in_budget"}, tt < LIM, 1);
        check_eq({tag, "_busy_cycles"}, busy_cnt, xb);
        check_eq({tag, "_writes"}, wr_cnt, xw);
        check_eq({tag, "_queue_empty"}, q_idx.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        k_dim = '0; m_dim = '0; n_dim = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_c_wr_en", c_wr_en, 0);
        check_eq("rst_a_index", a_index, 0);
        check_eq("rst_b_index", b_index, 0);
        check_eq("rst_c_index", c_index, 0);
        check_eq("rst_c_data", c_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill(0, 8'h00);
        run_job("ident", 4, 4, 4, 1'b0);
        fill(1, 8'h01);
        run_job("ones", 3, 5, 6, 1'b0);
        fill(1, 8'hFF);
        run_job("ff_k255", 255, 1, 1, 1'b0);

        a0 = a_index;
        run_job("k_zero", 0, 4, 4, 1'b0);
        check_eq("k_zero_no_read", a_index, a0);
        run_job("m_zero", 4, 0, 4, 1'b0);
        check_eq("m_zero_no_read", a_index, a0);

        fill(2, 8'h00);
        run_job("ignore_pulse", 5, 6, 3, 1'b1);
        fill(2, 8'h00);
        run_job("rand", 7, 8, 8, 1'b0);

        fill(2, 8'h00);
        load_job(3, 5, 4, eb, ew);
        start_cmd(3, 5, 4);
        t = 0;
        while (!c_wr_en && t < 200) begin
            @(negedge clk);
            t = t + 1;
        end
        check_eq("rst_mid_reached_write", c_wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_c_wr_en", c_wr_en, 0);
        check_eq("rst_mid_busy", busy, 0);
        q_idx.delete();
        q_dat.delete();
        repeat (2) @(negedge clk);
        check_eq("rst_hold_c_wr_en", c_wr_en, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_job("after_rst", 3, 5, 4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tpu_sa_core.md
# tpu_sa_core

Parametrised output-stationary systolic matrix-multiply engine computing C = A×B with A of size M×K and B of size K×N. It has a P×P processing-element (PE) grid and configurable operand and accumulator widths. It tiles M and N into P-wide blocks and streams operands from the A and B buffers. It writes one C row-slice per cycle to the C buffer and sits between the host command port and the three operand SRAMs.

## Interface
- P, 4, array dimension (rows = cols); 2..16
- DATA_W, 8, operand width per lane
- ACC_W, 32, accumulator width per PE
- DIM_W, 8, width of K/M/N
- IDX_W, 16, buffer index width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  command strobe; sampled only while busy=0
- K, M, N  in  DIM_W each  matrix dimensions, captured with in_valid
- busy  out  1  high from cycle after accepted command until job done
- A_wr_en, B_wr_en  out  1 each  tied 0
- A_index, B_index  out  IDX_W each  read addresses
- A_data_in, B_data_in  out  P*DATA_W each  tied 0
- A_data_out, B_data_out  in  P*DATA_W each  read data, 1-cycle latency after index
- C_wr_en  out  1  write strobe
- C_index  out  IDX_W  write address
- C_data_in  out  P*ACC_W  write data
- C_data_out  in  P*ACC_W  unused

## Operation
- Lane 0 is the MSB slice of every word.
- Buffer layout:
  - A word rb*K+k holds A[rb*P+i][k] in lane i.
  - B word cb*K+k holds B[k][cb*P+j] in lane j.
  - C word cb*M+m holds C[m][cb*P+j] in lane j.
  - Lanes beyond M or N hold zero in the C write.
- Tile counts: RB=ceil(M/P), CB=ceil(N/P). Tile order: cb outer, rb inner.
- FSM states: IDLE → FEED → DRAIN → WRITE, then either the next tile's FEED or DONE → IDLE.
- IDLE: command accepted when in_valid=1; K,M,N latched. If any dimension is 0, go straight to DONE and issue no reads or writes.
- FEED (K cycles): issue A_index=rb*K+t and B_index=cb*K+t for t=0..K-1. All P×P accumulators clear on the first FEED cycle.
- Skew: A lane i is delayed i cycles and enters row i. B lane j is delayed j cycles and enters column j. Operands shift right (A) and down (B) one PE per cycle. Bubbles are zero.
- Each PE accumulates acc += a*b when valid. The product is 2*DATA_W bits, extended to ACC_W. Accumulation wraps modulo 2^ACC_W.
- DRAIN: lasts 2P cycles after FEED.
- WRITE: rv=min(P, M−rb*P) cycles. Write r (r=0..rv-1) sets C_index=cb*M+rb*P+r and C_data_in = row r of the accumulators, with lanes cb*P+j≥N zeroed.
- in_valid while busy=1 is ignored.
- Reset mid-job: all state returns to IDLE immediately, busy=0, C_wr_en=0, job abandoned.

## Timing
- Reset values: busy=0, C_wr_en=0, all index and data outputs 0.
- Accepted in_valid at cycle c: busy=1 at c+1, first FEED read at c+1.
- For a tile whose first FEED cycle is T:
  - PE(i,j) receives operand k at T+k+2+i+j.
  - Last MAC is at T+K+2P−1.
  - The first C write is at T+K+2P, followed by rv consecutive writes.
- The next tile's FEED starts the cycle after the last write (no gap).
- Job length = Σtiles (K+2P+rv) cycles.
- busy falls the cycle after the last write (DONE lasts 1 cycle). The next command is accepted in the cycle busy=0 is observed.
- C_wr_en is high only in WRITE. C_index and C_data_in are registered and valid with C_wr_en.
- Index arithmetic is IDX_W bits. Overflow wraps and is not checked.

## Configuration
- TPU_SIGNED_EN:
  - Defined: operands are two's complement, products are sign-extended to ACC_W, and zero-bubbles are +0.
  - Undefined: operands are unsigned and products are zero-extended.
- Timing and layout are identical in both builds.

## Test plan
- P=4, K=M=N=4, A=B=identity → 4 writes at indices 0..3, row r has 1 in lane r and 0 elsewhere; busy high exactly 4+8+4+1=17 cycles.
- P=4, K=3, M=5, N=6, A and B all ones → 4 tiles. C values all 3, lanes for N columns 6,7 zero. Write counts 4,1,4,1 at indices 0..4 and 5..9.
- Operands 0xFF, K=255, M=N=1, ACC_W=16: the unsigned build gives 255·65025 mod 65536. The TPU_SIGNED_EN build gives 255 (sum of (−1)·(−1)).
- K=0 or M=0 command → busy high 1 cycle, zero C writes, zero reads.
- in_valid pulsed mid-job with different K → ignored; results match the first command.
- rst_n asserted during WRITE of a 2-tile job → C_wr_en=0 and busy=0 immediately. A fresh command then completes with correct results.
